// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage driven by the 3-bit ALU control code.
// Single-cycle ops finish on the accept edge; MUL/MOD iterate one operand bit per cycle.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             div_by_zero
);
   // state  | meaning
   // S_IDLE | waiting for an op, start_ready high
   // S_CALC | MUL/MOD iterating, one bit per cycle
   // S_DONE | result/flags presented until result_ready

   localparam int CW = $clog2(WIDTH);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_LSR = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MOV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a, r_b, r_acc;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_z, r_n, r_c, r_v, r_dbz;

   logic             w_accept, w_to_calc, w_last;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_diff, w_res;
   logic             w_c, w_v, w_dbz;
   logic [WIDTH-1:0] w_mul_acc, w_rem_nxt, w_step;
   logic [WIDTH:0]   w_rem_sh;

   assign start_ready  = (r_state == S_IDLE);
   assign result_valid = (r_state == S_DONE);
   assign result       = r_result;
   assign flag_z       = r_z;
   assign flag_n       = r_n;
   assign flag_c       = r_c;
   assign flag_v       = r_v;
   assign div_by_zero  = r_dbz;

   assign w_accept  = start_valid & start_ready;
   assign w_to_calc = (alu_control == OP_MUL) || ((alu_control == OP_MOD) && (src_b != '0));
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_to_calc ? S_CALC : S_DONE;
         S_CALC:  if (w_last) w_state_nxt = S_DONE;
         S_DONE:  if (result_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Single-cycle results, computed straight from the inputs on the accept edge
   always_comb begin
      w_sum  = {1'b0, src_a} + {1'b0, src_b};
      w_diff = src_a - src_b;
      w_res  = '0;
      w_c    = 1'b0;
      w_v    = 1'b0;
      w_dbz  = 1'b0;
      case (alu_control)
         OP_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_LSR: w_res = (src_b >= WIDTH'(WIDTH)) ? '0 : (src_a >> src_b);
         OP_SUB: begin
            w_res = w_diff;
            w_c   = (src_a >= src_b);
            w_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_MOV: w_res = src_b;
         OP_MOD: begin
            // only reaches DONE directly when the divisor is zero
            w_res = src_a;
            w_dbz = 1'b1;
         end
         default: w_res = '0;
      endcase
   end

   // One iteration: MUL shifts the multiplicand left / multiplier right,
   // the remainder path shifts the dividend's next bit into the partial remainder.
   always_comb begin
      w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;
      w_rem_sh  = {r_acc, r_a[WIDTH-1]};
      w_rem_nxt = w_rem_sh[WIDTH-1:0];
      if (w_rem_sh >= {1'b0, r_b}) w_rem_nxt = WIDTH'(w_rem_sh - {1'b0, r_b});
      w_step = (r_op == OP_MUL) ? w_mul_acc : w_rem_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_z      <= 1'b0;
         r_n      <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
         r_dbz    <= 1'b0;
      end else if (w_accept) begin
         r_op  <= alu_control;
         r_a   <= src_a;
         r_b   <= src_b;
         r_acc <= '0;
         r_cnt <= '0;
         if (!w_to_calc) begin
            r_result <= w_res;
            r_z      <= (w_res == '0);
            r_n      <= w_res[WIDTH-1];
            r_c      <= w_c;
            r_v      <= w_v;
            r_dbz    <= w_dbz;
         end
      end else if (r_state == S_CALC) begin
         r_acc <= w_step;
         r_cnt <= r_cnt + CW'(1);
         r_a   <= r_a << 1;
         if (r_op == OP_MUL) r_b <= r_b >> 1;
         if (w_last) begin
            r_result <= w_step;
            r_z      <= (w_step == '0);
            r_n      <= w_step[WIDTH-1];
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_dbz    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized ops checked against an arithmetic model;
// a negedge compare process checks every cycle a result is presented.
module tb_alu_exec_unit;
   localparam int W = 32;
   localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
   localparam longint SMIN = -(longint'(1) <<< (W - 1));

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_valid = 1'b0;
   logic         start_ready;
   logic [2:0]   alu_control = '0;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic         result_valid;
   logic         result_ready = 1'b0;
   logic [W-1:0] result;
   logic         flag_z, flag_n, flag_c, flag_v, div_by_zero;

   int checks = 0;
   int failures = 0;

   logic         exp_valid = 1'b0;
   logic [W-1:0] exp_res = '0;
   logic [4:0]   exp_flags = '0;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
      .result_valid(result_valid), .result_ready(result_ready),
      .result(result), .flag_z(flag_z), .flag_n(flag_n),
      .flag_c(flag_c), .flag_v(flag_v), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: flags packed as {z, n, c, v, dbz}
   function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic [4:0] f, output int lat);
      longint sa, sb, sr;
      logic [63:0] wide;
      logic c, v, d;
      c = 1'b0; v = 1'b0; d = 1'b0; lat = 1;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: begin
            wide = 64'(a) + 64'(b);
            r = wide[W-1:0];
            c = wide[W];
            sr = sa + sb;
            v = (sr > SMAX) || (sr < SMIN);
         end
         3'd1: r = (b >= W) ? '0 : (a >> b);
         3'd2: begin
            r = a - b;
            c = (a >= b);
            sr = sa - sb;
            v = (sr > SMAX) || (sr < SMIN);
         end
         3'd3: r = b;
         3'd4: begin
            if (b == 0) begin r = a; d = 1'b1; end
            else begin r = a % b; lat = W + 1; end
         end
         3'd6: begin
            wide = 64'(a) * 64'(b);
            r = wide[W-1:0];
            lat = W + 1;
         end
         default: r = '0;
      endcase
      f = {(r == 0), r[W-1], c, v, d};
   endfunction

   always @(negedge clk) begin
      if (rst_n && result_valid) begin
         if (!exp_valid) chk("spurious_result_valid", 1, 0);
         else begin
            chk("cmp_result", result, exp_res);
            chk("cmp_flags", {flag_z, flag_n, flag_c, flag_v, div_by_zero}, exp_flags);
            chk("cmp_ready_low_in_done", start_ready, 0);
         end
      end
   end

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit has_lit, input logic [W-1:0] lit_r,
                         input logic [4:0] lit_f, input string name);
      int n, lat, mlat;
      logic [W-1:0] mr;
      logic [4:0] mf;
      logic [W+4:0] snap;
      model(op, a, b, mr, mf, mlat);
      n = 0;
      @(negedge clk);
      while (!start_ready && n < 100) begin @(negedge clk); n++; end
      chk({name, "_ready_wait"}, start_ready, 1);
      alu_control = op; src_a = a; src_b = b; start_valid = 1'b1;
      @(posedge clk); #1;
      exp_res = mr; exp_flags = mf; exp_valid = 1'b1;
      lat = 1;
      forever begin
         // noise on the inputs must not disturb the op in flight
         start_valid = 1'($urandom_range(0, 1));
         alu_control = 3'($urandom);
         src_a = $urandom;
         src_b = $urandom;
         @(negedge clk);
         if (result_valid || lat > 200) break;
         chk({name, "_ready_low_busy"}, start_ready, 0);
         @(posedge clk);
         lat++;
      end
      start_valid = 1'b0;
      chk({name, "_latency"}, lat, mlat);
      if (has_lit) begin
         chk({name, "_lit_result"}, result, lit_r);
         chk({name, "_lit_flags"}, {flag_z, flag_n, flag_c, flag_v, div_by_zero}, lit_f);
      end
      snap = {result, flag_z, flag_n, flag_c, flag_v, div_by_zero};
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
         chk({name, "_hold_valid"}, result_valid, 1);
         chk({name, "_hold_stable"}, {result, flag_z, flag_n, flag_c, flag_v, div_by_zero}, snap);
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      exp_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int hold;
      logic [2:0] op;
      logic [W-1:0] a, b;
      #23;
      chk("reset_outputs", {result_valid, result, flag_z, flag_n, flag_c, flag_v, div_by_zero}, 0);
      chk("reset_ready", start_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(3'd0, 32'hFFFF_FFFF, 32'd1, 0, 1, 32'd0, 5'b10100, "add_wrap");
      run_op(3'd2, 32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 5'b01000, "sub_neg");
      run_op(3'd2, 32'h8000_0000, 32'd1, 0, 1, 32'h7FFF_FFFF, 5'b00110, "sub_ovf");
      run_op(3'd6, 32'd1234, 32'd5678, 5, 1, 32'd7006652, 5'b00000, "mul_bp");
      run_op(3'd4, 32'd100, 32'd7, 0, 1, 32'd2, 5'b00000, "mod");
      run_op(3'd4, 32'd9, 32'd0, 2, 1, 32'd9, 5'b00001, "mod_dz");
      run_op(3'd1, 32'hF000_0000, 32'd4, 0, 1, 32'h0F00_0000, 5'b00000, "lsr4");
      run_op(3'd1, 32'hF000_0000, 32'd40, 0, 1, 32'd0, 5'b10000, "lsr40");
      run_op(3'd3, 32'd17, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 5'b01000, "mov");
      run_op(3'd7, 32'd3, 32'd4, 0, 1, 32'd0, 5'b10000, "none");
      run_op(3'd5, 32'd3, 32'd4, 0, 1, 32'd0, 5'b10000, "unused101");

      // reset in the middle of a multiply
      @(negedge clk);
      alu_control = 3'd6; src_a = 32'd3; src_b = 32'd7; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      chk("rst_mid_busy", start_ready, 0);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", {result_valid, result, flag_z, flag_n, flag_c, flag_v, div_by_zero}, 0);
      chk("rst_mid_ready", start_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'd6, 32'd1234, 32'd5678, 0, 1, 32'd7006652, 5'b00000, "mul_after_rst");

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(0, 40));
            1:       b = '0;
            default: b = $urandom;
         endcase
         hold = $urandom_range(0, 3);
         run_op(op, a, b, hold, 0, '0, '0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
